// File: rtl/spi_slave_sys.sv
// System-clock SPI slave: oversampled sclk/cs/mosi, configurable width,
// CPOL/CPHA and bit order, frame-error detection and back-to-back frames.
module spi_slave_sys #(
  parameter int DATA_W    = 8,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              done,
  output logic              busy,
  output logic              frame_err
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] FULL = CW'(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t state_q, state_d;

  logic [2:0]        sclk_s, cs_s;
  logic [1:0]        mosi_s;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] rx_shift, tx_shift;
  logic [DATA_W-1:0] rx_nxt, tx_adv;
  logic lead_edge, trail_edge;
  logic sample_edge, shift_edge;
  logic cs_fall, cs_rise;
  logic mosi_b, full, last_smp;

  function automatic logic first_bit(
    input logic [DATA_W-1:0] w
  );
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s <= {3{CPOL}};
      cs_s   <= 3'b111;
      mosi_s <= 2'b00;
    end else begin
      sclk_s <= {sclk_s[1:0], sclk};
      cs_s   <= {cs_s[1:0], cs};
      mosi_s <= {mosi_s[0], mosi};
    end
  end

  assign lead_edge   = (sclk_s[2] == CPOL) &&
                       (sclk_s[1] != CPOL);
  assign trail_edge  = (sclk_s[2] != CPOL) &&
                       (sclk_s[1] == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign cs_fall     = cs_s[2] & ~cs_s[1];
  assign cs_rise     = ~cs_s[2] & cs_s[1];
  assign mosi_b      = mosi_s[1];
  assign full        = (bit_cnt == FULL);
  assign last_smp    = sample_edge && (bit_cnt == LAST);
  assign busy        = (state_q == XFER);

  assign rx_nxt = MSB_FIRST ?
    {rx_shift[DATA_W-2:0], mosi_b} :
    {mosi_b, rx_shift[DATA_W-1:1]};
  assign tx_adv = MSB_FIRST ?
    (tx_shift << 1) : (tx_shift >> 1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = XFER;
      XFER:    if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      rx_data   <= '0;
      miso      <= 1'b0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      done      <= 1'b0;
      frame_err <= 1'b0;
      if (full) begin
        rx_data <= rx_shift;
        done    <= 1'b1;
        bit_cnt <= '0;
        if (state_q == XFER) begin
          if (!cs_s[1]) begin
            tx_shift <= tx_data;
            if (!CPHA) miso <= first_bit(tx_data);
          end else begin
            miso <= 1'b0;
          end
        end
      end else if (state_q == IDLE) begin
        if (cs_fall) begin
          tx_shift <= tx_data;
          bit_cnt  <= '0;
          miso     <= CPHA ? 1'b0 : first_bit(tx_data);
        end
      end else if (cs_rise) begin
        miso <= 1'b0;
        // a final sample racing cs rise still completes the word
        if (last_smp) begin
          rx_shift <= rx_nxt;
          bit_cnt  <= FULL;
        end else begin
          frame_err <= (bit_cnt != '0);
          bit_cnt   <= '0;
        end
      end else begin
        if (sample_edge) begin
          rx_shift <= rx_nxt;
          bit_cnt  <= bit_cnt + CW'(1);
        end
        // bit_cnt==0 on a shift edge: CPHA=1 first bit,
        // or CPHA=0 trailing edge after a completed word
        if (shift_edge) begin
          if (bit_cnt == '0) begin
            if (CPHA) miso <= first_bit(tx_shift);
          end else begin
            tx_shift <= tx_adv;
            miso     <= first_bit(tx_adv);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_sys.sv
// Bench for spi_slave_sys: mode 0 / 8-bit MSB-first and
// mode 3 / 16-bit LSB-first slaves driven by a behavioural SPI master.
module tb_spi_slave_sys;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk0 = 1'b0;
  logic sclk1 = 1'b1;
  logic cs = 1'b1;
  logic mosi = 1'b0;
  logic [7:0]  tx0 = '0;
  logic [7:0]  rx0;
  logic [15:0] tx1 = '0;
  logic [15:0] rx1;
  logic miso0, miso1, done0, done1;
  logic busy0, busy1, ferr0, ferr1;

  int tests = 0;
  int fails = 0;
  int dn0 = 0, dn1 = 0, fe0 = 0, fe1 = 0;
  logic [31:0] rxq0[$];
  bit busy_seen0 = 1'b0;

  always #5 clk = ~clk;

  spi_slave_sys #(
    .DATA_W(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)
  ) u0 (
    .clk(clk), .rst(rst), .sclk(sclk0), .cs(cs),
    .mosi(mosi), .miso(miso0), .tx_data(tx0),
    .rx_data(rx0), .done(done0), .busy(busy0),
    .frame_err(ferr0)
  );

  spi_slave_sys #(
    .DATA_W(16), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)
  ) u1 (
    .clk(clk), .rst(rst), .sclk(sclk1), .cs(cs),
    .mosi(mosi), .miso(miso1), .tx_data(tx1),
    .rx_data(rx1), .done(done1), .busy(busy1),
    .frame_err(ferr1)
  );

  always @(negedge clk) begin
    if (done0) begin
      dn0++;
      rxq0.push_back(32'(rx0));
    end
    if (done1) dn1++;
    if (ferr0) fe0++;
    if (ferr1) fe1++;
    if (busy0) busy_seen0 = 1'b1;
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_sclk(input int sel, input logic v);
    if (sel == 0) sclk0 = v;
    else          sclk1 = v;
  endtask

  task automatic set_tx(input int sel, input logic [31:0] v);
    if (sel == 0) tx0 = v[7:0];
    else          tx1 = v[15:0];
  endtask

  // master: sel 0 = mode 0 MSB-first 8b, sel 1 = mode 3 LSB-first 16b
  task automatic spi_bits(input int sel, input int n,
                          input logic [31:0] word,
                          input logic [31:0] nxt,
                          output logic [31:0] got);
    logic [31:0] g;
    int w, idx;
    logic cpol;
    g = '0;
    w = (sel == 0) ? 8 : 16;
    cpol = (sel != 0);
    for (int i = 0; i < n; i++) begin
      idx = (sel == 0) ? (w - 1 - i) : i;
      if (sel == 0) begin
        mosi = word[idx];
        hold(4);
        g[idx] = miso0;
        set_sclk(sel, ~cpol);
        hold(4);
        set_sclk(sel, cpol);
      end else begin
        set_sclk(sel, ~cpol);
        mosi = word[idx];
        hold(4);
        g[idx] = miso1;
        set_sclk(sel, cpol);
        hold(4);
      end
      if (i == 0) set_tx(sel, nxt);
    end
    got = g;
  endtask

  task automatic frame(input int sel, input logic [31:0] word,
                       input logic [31:0] tx,
                       output logic [31:0] got,
                       output logic bmid);
    set_tx(sel, tx);
    cs = 1'b0;
    hold(8);
    bmid = (sel == 0) ? busy0 : busy1;
    spi_bits(sel, (sel == 0) ? 8 : 16, word, tx, got);
    hold(4);
    cs = 1'b1;
    hold(12);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    hold(3);
    tests++;
    if ({miso0, done0, busy0, ferr0, rx0} !== 12'h0) begin
      fails++;
      $display("FAIL reset0 got %h want 0",
               {miso0, done0, busy0, ferr0, rx0});
    end
    tests++;
    if ({miso1, done1, busy1, ferr1, rx1} !== 20'h0) begin
      fails++;
      $display("FAIL reset1 got %h want 0",
               {miso1, done1, busy1, ferr1, rx1});
    end
    rst = 1'b0;
    hold(4);
  endtask

  task automatic test_mode0;
    logic [31:0] got, w, t;
    logic bm;
    int d;
    d = dn0;
    frame(0, 32'hA5, 32'h3C, got, bm);
    tests++;
    if (rx0 !== 8'hA5) begin
      fails++; $display("FAIL m0_rx got %h want a5", rx0);
    end
    tests++;
    if (got !== 32'h3C) begin
      fails++; $display("FAIL m0_miso got %h want 3c", got);
    end
    tests++;
    if (dn0 - d !== 1) begin
      fails++; $display("FAIL m0_done got %0d want 1", dn0 - d);
    end
    tests++;
    if (bm !== 1'b1) begin
      fails++; $display("FAIL m0_busy_mid got %b want 1", bm);
    end
    tests++;
    if (busy0 !== 1'b0) begin
      fails++; $display("FAIL m0_busy_end got %b want 0", busy0);
    end
    tests++;
    if (miso0 !== 1'b0) begin
      fails++; $display("FAIL m0_miso_idle got %b want 0", miso0);
    end
    for (int k = 0; k < 4; k++) begin
      w = 32'($urandom_range(0, 255));
      t = 32'($urandom_range(0, 255));
      d = dn0;
      frame(0, w, t, got, bm);
      tests++;
      if (rx0 !== w[7:0] || dn0 - d !== 1) begin
        fails++;
        $display("FAIL m0_rand_rx got %h/%0d want %h/1",
                 rx0, dn0 - d, w[7:0]);
      end
      tests++;
      if (got !== t) begin
        fails++;
        $display("FAIL m0_rand_miso got %h want %h", got, t);
      end
    end
  endtask

  task automatic test_mode3_lsb;
    logic [31:0] got, w, t;
    logic bm;
    int d;
    d = dn1;
    frame(1, 32'h1234, 32'hBEEF, got, bm);
    tests++;
    if (rx1 !== 16'h1234) begin
      fails++; $display("FAIL m3_rx got %h want 1234", rx1);
    end
    tests++;
    if (got !== 32'hBEEF) begin
      fails++; $display("FAIL m3_miso got %h want beef", got);
    end
    tests++;
    if (dn1 - d !== 1) begin
      fails++; $display("FAIL m3_done got %0d want 1", dn1 - d);
    end
    tests++;
    if (busy1 !== 1'b0 || miso1 !== 1'b0) begin
      fails++;
      $display("FAIL m3_idle got %b%b want 00", busy1, miso1);
    end
    for (int k = 0; k < 3; k++) begin
      w = 32'($urandom_range(0, 65535));
      t = 32'($urandom_range(0, 65535));
      d = dn1;
      frame(1, w, t, got, bm);
      tests++;
      if (rx1 !== w[15:0] || dn1 - d !== 1) begin
        fails++;
        $display("FAIL m3_rand_rx got %h/%0d want %h/1",
                 rx1, dn1 - d, w[15:0]);
      end
      tests++;
      if (got !== t) begin
        fails++;
        $display("FAIL m3_rand_miso got %h want %h", got, t);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] t[3];
    logic [31:0] g[3];
    logic [31:0] q;
    int d;
    for (int k = 0; k < 3; k++)
      t[k] = 32'($urandom_range(0, 255));
    rxq0.delete();
    d = dn0;
    set_tx(0, t[0]);
    cs = 1'b0;
    hold(8);
    for (int k = 0; k < 3; k++)
      spi_bits(0, 8, 32'(k + 1), t[(k < 2) ? k + 1 : 2], g[k]);
    hold(4);
    cs = 1'b1;
    hold(12);
    tests++;
    if (dn0 - d !== 3) begin
      fails++; $display("FAIL b2b_done got %0d want 3", dn0 - d);
    end
    for (int k = 0; k < 3; k++) begin
      q = (rxq0.size() > k) ? rxq0[k] : 32'hxxxxxxxx;
      tests++;
      if (q !== 32'(k + 1)) begin
        fails++;
        $display("FAIL b2b_rx%0d got %h want %h", k, q, k + 1);
      end
      tests++;
      if (g[k] !== t[k]) begin
        fails++;
        $display("FAIL b2b_miso%0d got %h want %h", k, g[k], t[k]);
      end
    end
  endtask

  task automatic test_abort;
    logic [31:0] got;
    logic bm;
    int d, f;
    frame(0, 32'hA5, 32'h00, got, bm);
    d = dn0;
    f = fe0;
    set_tx(0, 32'($urandom_range(0, 255)));
    cs = 1'b0;
    hold(8);
    spi_bits(0, 5, 32'($urandom_range(0, 255)), 32'h0, got);
    hold(4);
    cs = 1'b1;
    hold(12);
    tests++;
    if (fe0 - f !== 1) begin
      fails++; $display("FAIL abort_ferr got %0d want 1", fe0 - f);
    end
    tests++;
    if (dn0 - d !== 0) begin
      fails++; $display("FAIL abort_done got %0d want 0", dn0 - d);
    end
    tests++;
    if (rx0 !== 8'hA5) begin
      fails++; $display("FAIL abort_rx got %h want a5", rx0);
    end
    tests++;
    if (miso0 !== 1'b0) begin
      fails++; $display("FAIL abort_miso got %b want 0", miso0);
    end
    tests++;
    if (busy0 !== 1'b0) begin
      fails++; $display("FAIL abort_busy got %b want 0", busy0);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] got, t;
    logic bm;
    int d, f;
    d = dn0;
    f = fe0;
    cs = 1'b0;
    hold(8);
    spi_bits(0, 4, 32'($urandom_range(0, 255)), 32'h0, got);
    rst = 1'b1;
    cs = 1'b1;
    hold(2);
    tests++;
    if ({miso0, done0, busy0, ferr0, rx0} !== 12'h0) begin
      fails++;
      $display("FAIL rstmid_out got %h want 0",
               {miso0, done0, busy0, ferr0, rx0});
    end
    hold(2);
    rst = 1'b0;
    hold(12);
    tests++;
    if (dn0 - d !== 0) begin
      fails++; $display("FAIL rstmid_done got %0d want 0", dn0 - d);
    end
    tests++;
    if (fe0 - f !== 0) begin
      fails++; $display("FAIL rstmid_ferr got %0d want 0", fe0 - f);
    end
    t = 32'($urandom_range(0, 255));
    d = dn0;
    frame(0, 32'h5A, t, got, bm);
    tests++;
    if (rx0 !== 8'h5A || dn0 - d !== 1) begin
      fails++;
      $display("FAIL rstmid_rx got %h/%0d want 5a/1", rx0, dn0 - d);
    end
    tests++;
    if (got !== t) begin
      fails++; $display("FAIL rstmid_miso got %h want %h", got, t);
    end
  endtask

  task automatic test_idle_glitch;
    int d;
    d = dn0;
    busy_seen0 = 1'b0;
    cs = 1'b1;
    for (int i = 0; i < 20; i++) begin
      mosi = 1'($urandom_range(0, 1));
      sclk0 = ~sclk0;
      hold(4);
    end
    hold(8);
    tests++;
    if (dn0 - d !== 0) begin
      fails++; $display("FAIL idle_done got %0d want 0", dn0 - d);
    end
    tests++;
    if (busy_seen0 !== 1'b0) begin
      fails++; $display("FAIL idle_busy got %b want 0", busy_seen0);
    end
    tests++;
    if (miso0 !== 1'b0) begin
      fails++; $display("FAIL idle_miso got %b want 0", miso0);
    end
  endtask

  initial begin
    test_reset;
    test_mode0;
    test_mode3_lsb;
    test_back_to_back;
    test_abort;
    test_reset_mid;
    test_idle_glitch;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_slave_sys.md
Name: spi_slave_sys

Overview:
- System-clock-domain SPI slave, full duplex. Receives a word on mosi and returns a word on miso.
- Generalises the sclk-clocked 8-bit slave: parametrised word width, CPOL/CPHA mode and bit order; oversampled synchronised inputs; frame-error detection; back-to-back frames.
- Sits between an external SPI master and the on-chip FSM/register logic. That logic runs on clk.

Parameters:
- DATA_W, 8: bits per frame, 2..32.
- CPOL, 0: sclk idle level.
- CPHA, 0: 0 = sample on leading edge; 1 = sample on trailing edge.
- MSB_FIRST, 1: 1 = MSB shifted first on both lines; 0 = LSB first.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- sclk  in  1  SPI clock, asynchronous to clk; frequency ≤ clk/8.
- cs  in  1  chip select, active low, asynchronous.
- mosi  in  1  serial data in, asynchronous.
- miso  out  1  serial data out; 0 when not selected (no tristate).
- tx_data  in  DATA_W  word to transmit; captured at frame start.
- rx_data  out  DATA_W  last complete received word.
- done  out  1  one-clk pulse: rx_data has just been updated.
- busy  out  1  high while in XFER.
- frame_err  out  1  one-clk pulse: cs rose mid-frame.

Behaviour:
- Reset (rst=1 at a clk edge) sets: state=IDLE, bit_cnt=0, shift regs=0, rx_data=0, miso=0, done=0, busy=0, frame_err=0, sync flops to idle (sclk=CPOL, cs=1, mosi=0). Reset mid-frame aborts the frame with no done and no frame_err.
- Input conditioning:
  - sclk, cs and mosi each pass through a 2-flop synchroniser. sclk and cs get a third flop for edge detection.
  - lead_edge = synchronised sclk leaves CPOL; trail_edge = synchronised sclk returns to CPOL.
  - sample_edge = lead_edge if CPHA=0, else trail_edge; shift_edge = the other edge.
  - mosi is taken from its 2-flop output, aligned with the sclk edge detect.
- State machine:
  - IDLE: on synchronised cs falling edge, load tx_shift←tx_data, bit_cnt←0, go to XFER, busy=1.
    - CPHA=0: miso presents the first bit (MSB or LSB per MSB_FIRST) in the same cycle as the load.
    - CPHA=1: miso stays 0 until the first shift_edge.
  - XFER on sample_edge: rx_shift takes mosi (shift left, inserting at bit0, if MSB_FIRST; otherwise shift right, inserting at bit DATA_W-1); bit_cnt+1.
  - XFER on shift_edge: tx_shift advances and miso presents the next bit.
    - CPHA=0: skip the advance on the final trailing edge after bit DATA_W.
    - CPHA=1: the first shift_edge presents bit 0 of the word without advancing.
  - The sample that makes bit_cnt=DATA_W:
    - Next clk: rx_data←assembled word, done=1 for exactly one clk, bit_cnt←0.
    - If cs is still low: reload tx_shift←tx_data and stay in XFER (back-to-back frame, no gap needed).
  - Synchronised cs rising edge in XFER:
    - bit_cnt=0: go to IDLE silently.
    - bit_cnt in 1..DATA_W-1: frame_err=1 for one clk, rx_data unchanged, partial word discarded, go to IDLE.
    - In both cases miso←0 and busy←0 in the same cycle.
  - cs rise and the final sample_edge detected in the same clk: the frame completes (done=1) and there is no frame_err. Then go to IDLE.
- sclk edges while cs is high are ignored.
- Latency: done asserts 1 clk after the synchronised final sample edge, which is ≤ 4 clk after the pin edge.
- bit_cnt is $clog2(DATA_W+1) bits wide. No arithmetic on data; the shift registers are exactly DATA_W wide.

Test Plan:
- Mode 0, DATA_W=8, MSB first, clk/8 sclk: master sends 0xA5 with tx_data=0x3C -> rx_data=0xA5, one done pulse, master receives 0x3C, busy falls after cs rise.
- CPOL=1/CPHA=1, DATA_W=16, MSB_FIRST=0: master sends 0x1234 with tx_data=0xBEEF -> rx_data=0x1234, master receives 0xBEEF LSB first.
- Back-to-back: cs held low for 3×8 bits (0x01, 0x02, 0x03), with tx_data changed between words -> three done pulses, each rx_data value correct, each miso word equal to tx_data at its frame boundary.
- Abort: cs rises after 5 bits -> frame_err is a single pulse, done=0, rx_data keeps its previous value 0xA5, miso=0.
- rst asserted at bit 4, then a full frame of 0x5A -> all outputs 0 during reset, no done/frame_err for the aborted frame, next frame gives rx_data=0x5A.
- Glitch-free idle: sclk toggling with cs=1 -> no done, busy stays 0, miso=0.
